// File: rtl/xosera_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xosera_intr_ctrl
// Brief    : Parametrised interrupt controller: sticky per-source status with
//            strobe/edge capture, mask, priority ID and one-cycle bus strobe.
//            Define INTR_HOLDOFF_EN to compile in interrupt coalescing.
// Revision : 1.0 - initial release
// ============================================================================
module xosera_intr_ctrl #(
  parameter int  NUM_SRC   = 4,
  parameter int  HOLDOFF_W = 8,
  localparam int ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic [NUM_SRC-1:0]   intr_signal_i,
  input  logic [NUM_SRC-1:0]   intr_edge_i,
  input  logic [NUM_SRC-1:0]   intr_mask_i,
  input  logic [NUM_SRC-1:0]   intr_clear_i,
  input  logic [NUM_SRC-1:0]   intr_force_i,
`ifdef INTR_HOLDOFF_EN
  input  logic [HOLDOFF_W-1:0] intr_holdoff_i,
`endif
  output logic [NUM_SRC-1:0]   intr_status_o,
  output logic [NUM_SRC-1:0]   intr_pending_o,
  output logic                 intr_any_o,
  output logic [ID_W-1:0]      intr_id_o,
  output logic                 bus_intr_o
);

  if (NUM_SRC < 1 || NUM_SRC > 16 || HOLDOFF_W < 1) begin : g_param_check
    $error("xosera_intr_ctrl: parameter out of range");
  end

  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_mask_q;
  logic [NUM_SRC-1:0] r_status;
  logic               r_bus_intr;

  logic [NUM_SRC-1:0] w_event;
  logic [NUM_SRC-1:0] w_new;
  logic [NUM_SRC-1:0] w_unmask;
  logic [NUM_SRC-1:0] w_pending;
  logic               w_any;
  logic [ID_W-1:0]    w_id;
  logic               w_req;
  logic               w_pulse;

  assign w_event  = intr_signal_i & (~intr_edge_i | ~r_prev);
  // Only a 0->1 status transition or an unmask of a held bit is news to the CPU
  assign w_new    = (w_event | intr_force_i) & ~r_status;
  assign w_unmask = r_status & intr_mask_i & ~r_mask_q;
  assign w_req    = |((w_new | w_unmask) & intr_mask_i & ~intr_clear_i);

  assign w_pending = r_status & intr_mask_i;
  assign w_any     = |w_pending;

  always_comb begin
    w_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_pending[i]) w_id = ID_W'(i);
    end
  end

  // History loads during reset so a source already high at release stays quiet
  always_ff @(posedge clk) begin
    r_prev   <= intr_signal_i;
    r_mask_q <= intr_mask_i;
    if (reset_i) begin
      r_status   <= '0;
      r_bus_intr <= 1'b0;
    end else begin
      r_status   <= (r_status | w_event | intr_force_i) & ~intr_clear_i;
      r_bus_intr <= w_pulse;
    end
  end

`ifdef INTR_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] r_holdoff_cnt;
  logic                 r_deferred;
  logic                 w_cnt_zero;

  assign w_cnt_zero = (r_holdoff_cnt == '0);
  assign w_pulse    = w_cnt_zero & (w_req | (r_deferred & w_any));

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_holdoff_cnt <= '0;
      r_deferred    <= 1'b0;
    end else if (w_pulse) begin
      r_holdoff_cnt <= intr_holdoff_i;
      r_deferred    <= 1'b0;
    end else begin
      if (!w_cnt_zero) r_holdoff_cnt <= r_holdoff_cnt - 1'b1;
      // A request here can only happen inside the holdoff window
      if (w_req)       r_deferred <= 1'b1;
      else if (!w_any) r_deferred <= 1'b0;
    end
  end
`else
  assign w_pulse = w_req;
`endif

  assign intr_status_o  = r_status;
  assign intr_pending_o = w_pending;
  assign intr_any_o     = w_any;
  assign intr_id_o      = w_id;
  assign bus_intr_o     = r_bus_intr;

endmodule
`default_nettype wire

// File: doc/xosera_intr_ctrl.md
Name: xosera_intr_ctrl

Overview:
Parametrised interrupt controller; the successor to the fixed 4-bit interrupt logic inside the top-level module.
- Collects NUM_SRC interrupt sources (video, blitter, copper, future audio/draw), each configurable as strobe or rising-edge.
- Keeps per-source sticky status with CPU clear/force, applies mask, produces a one-cycle bus interrupt strobe and a priority-encoded pending ID.
- Sits between the source units and reg_interface / the bus_intr_o pin.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..16).
HOLDOFF_W, 8, width of holdoff counter (used only with the optional feature).

Ports:
clk  input  1  pixel clock
reset_i  input  1  reset
intr_signal_i  input  NUM_SRC  raw source signals
intr_edge_i  input  NUM_SRC  per source: 1 = rising-edge detect, 0 = strobe (high = event every cycle)
intr_mask_i  input  NUM_SRC  1 = source enabled to interrupt CPU
intr_clear_i  input  NUM_SRC  one-cycle strobe; clears status bits
intr_force_i  input  NUM_SRC  one-cycle strobe; software-set status bits
intr_holdoff_i  input  HOLDOFF_W  minimum cycles between bus_intr_o pulses (port exists only with INTR_HOLDOFF_EN)
intr_status_o  output  NUM_SRC  sticky status (registered)
intr_pending_o  output  NUM_SRC  intr_status_o & intr_mask_i
intr_any_o  output  1  |intr_pending_o
intr_id_o  output  max(1,$clog2(NUM_SRC))  lowest index set in intr_pending_o; 0 when none
bus_intr_o  output  1  one-cycle CPU interrupt strobe (registered)

Behaviour:
- Clock and reset: single clock clk. reset_i is synchronous, active-high.
- Reset values:
  - intr_status_o = 0, bus_intr_o = 0, holdoff counter = 0, deferred flag = 0.
  - The edge-detect history register loads intr_signal_i during reset, so a source already high at reset release does not fire.
- Event generation: event[i] = intr_edge_i[i] ? (intr_signal_i[i] & ~prev[i]) : intr_signal_i[i]. prev updates every cycle.
- Status update:
  - status <= (status | event | intr_force_i) & ~intr_clear_i.
  - Clear wins over a simultaneous event or force on the same bit.
- New-interrupt request (combinational):
  - req = |(((event | intr_force_i) & ~status) | (status & intr_mask_i & ~mask_q)) & intr_mask_i & ~intr_clear_i)
  - mask_q is intr_mask_i registered.
  - Result: a masked source firing while its status is clear requests an interrupt.
  - Re-firing while status is already set does not request.
  - Unmasking an already-set status bit requests once.
- Pulse timing: bus_intr_o <= req, so the pulse appears the cycle after the event and lasts exactly one cycle.
- Pending outputs: intr_pending_o, intr_any_o and intr_id_o are combinational from registered status and the live mask, so they are valid the cycle after the event. Lowest index has highest priority.
- Register writes from reg_interface drive intr_clear_i / intr_force_i as single-cycle strobes. Multi-cycle assertion is legal and idempotent.

Optional Feature:
INTR_HOLDOFF_EN
- With the macro defined, interrupt coalescing is compiled in:
  - Whenever bus_intr_o <= 1 is scheduled, counter <= intr_holdoff_i; otherwise counter decrements while nonzero.
  - A req while counter != 0 sets the deferred flag; no pulse is issued.
  - When counter == 0, the pulse condition is req | (deferred & intr_any_o). A pulse clears deferred.
  - If deferred is set but intr_any_o == 0 (all cleared), deferred clears silently.
  - intr_holdoff_i = 0 behaves identically to the macro undefined.
- Without the macro: intr_holdoff_i is absent, there is no counter, and bus_intr_o <= req.

Test Plan:
1. Reset asserted 3 cycles with intr_signal_i=4'b1111, intr_edge_i=4'b1111, then released with signals held -> all outputs 0; no status bits set afterward.
2. mask=4'b0010, strobe mode, intr_signal_i[1] high one cycle at T -> at T+1: status=4'b0010, bus_intr_o=1 (only T+1), any=1, id=1.
3. Same bit strobed again at T+5 -> no bus_intr_o. Then mask=4'b0000 at T+8 and 4'b0010 at T+10 -> bus_intr_o at T+11. Then clear=4'b0010 -> status=0, any=0.
4. mask=4'b0100, intr_signal_i[2] and intr_clear_i[2] same cycle -> status[2]=0, no bus_intr_o. Force=4'b1001 with mask=4'b1001 -> status=4'b1001, one pulse, id=0.
5. Edge mode src3 (mask=4'b1000) held high 10 cycles -> status[3] set once, one pulse. Clear while still high -> stays 0. Low then high -> set again, second pulse.
6. INTR_HOLDOFF_EN, holdoff=5, mask=4'b0011: src0 at T, src1 at T+2 -> pulses at T+1 and T+7, none between. Repeat with both cleared at T+4 -> only the T+1 pulse.
